// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX-stage branches against queued fetch predictions, drives flush/redirect and stats
module branch_resolve_unit #(
    parameter int PRED_Q_DEPTH = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pred_valid,
    input  logic        pred_taken,
    input  logic [31:0] pred_pc,
    output logic        pred_ready,
    input  logic        ex_valid,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    output logic        actual_outcome,
    output logic        branch_EX_done,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        orphan_err,
    output logic [15:0] branch_cnt,
    output logic [15:0] mispredict_cnt
);
    localparam int AW = $clog2(PRED_Q_DEPTH);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    typedef enum logic {IDLE, FLUSH} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [32:0] mem_q [PRED_Q_DEPTH];
    logic [32:0] mem_d [PRED_Q_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic done_q, done_d, outcome_q, outcome_d, redir_v_q, redir_v_d, orphan_q, orphan_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [15:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;
    logic full, empty, accept, push, pop, hit, predicted, taken, valid_op, mispredict;
    logic eq, lt, ltu;
    logic [32:0] head;

    assign full       = cnt_q == (AW+1)'(PRED_Q_DEPTH);
    assign empty      = cnt_q == '0;
    assign flush      = state_q == FLUSH;
    assign pred_ready = !full && !flush;
    assign accept     = ex_valid && state_q == IDLE;
    assign push       = pred_valid && pred_ready;
    assign pop        = accept && !empty;
    assign head       = mem_q[rd_q];
    // An orphan (empty queue or PC mismatch) is resolved as predicted not-taken
    assign hit        = !empty && head[31:0] == ex_pc;
    assign predicted  = hit && head[32];
    assign eq         = ex_rs1 == ex_rs2;
    assign lt         = $signed(ex_rs1) < $signed(ex_rs2);
    assign ltu        = ex_rs1 < ex_rs2;
    assign valid_op   = ex_funct3[2] || !ex_funct3[1];
    assign taken      = ex_funct3[2] ? ((ex_funct3[1] ? ltu : lt) ^ ex_funct3[0])
                                     : (!ex_funct3[1] && (eq ^ ex_funct3[0]));
    assign mispredict = accept && taken != predicted;

    assign actual_outcome = outcome_q;
    assign branch_EX_done = done_q;
    assign redirect_valid = redir_v_q;
    assign redirect_pc    = redir_pc_q;
    assign orphan_err     = orphan_q;
    assign branch_cnt     = bcnt_q;
    assign mispredict_cnt = mcnt_q;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = {pred_taken, pred_pc};
        wr_d       = mispredict ? '0 : wr_q + AW'(push);
        rd_d       = mispredict ? '0 : rd_q + AW'(pop);
        cnt_d      = mispredict ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        state_d    = mispredict ? FLUSH : (flush && fcnt_q == CW'(1)) ? IDLE : state_q;
        fcnt_d     = mispredict ? CW'(FLUSH_CYCLES) : flush ? fcnt_q - CW'(1) : fcnt_q;
        done_d     = accept;
        outcome_d  = accept ? taken : outcome_q;
        redir_v_d  = mispredict;
        redir_pc_d = mispredict ? (taken ? ex_target : ex_pc + 32'd4) : redir_pc_q;
        orphan_d   = orphan_q || (accept && !hit);
        bcnt_d     = (accept && valid_op && bcnt_q != 16'hFFFF) ? bcnt_q + 16'd1 : bcnt_q;
        mcnt_d     = (mispredict && mcnt_q != 16'hFFFF) ? mcnt_q + 16'd1 : mcnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PRED_Q_DEPTH; i++) mem_q[i] <= '0;
            state_q    <= IDLE;
            fcnt_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            outcome_q  <= 1'b0;
            redir_v_q  <= 1'b0;
            redir_pc_q <= '0;
            orphan_q   <= 1'b0;
            bcnt_q     <= '0;
            mcnt_q     <= '0;
        end else begin
            mem_q      <= mem_d;
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            outcome_q  <= outcome_d;
            redir_v_q  <= redir_v_d;
            redir_pc_q <= redir_pc_d;
            orphan_q   <= orphan_d;
            bcnt_q     <= bcnt_d;
            mcnt_q     <= mcnt_d;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst_n, pred_valid, pred_taken, pred_ready, ex_valid;
    logic [2:0]  ex_funct3;
    logic [31:0] pred_pc, ex_rs1, ex_rs2, ex_pc, ex_target, redirect_pc;
    logic        actual_outcome, branch_EX_done, flush, redirect_valid, orphan_err;
    logic [15:0] branch_cnt, mispredict_cnt;
    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(.PRED_Q_DEPTH(4), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc), .pred_ready(pred_ready),
        .ex_valid(ex_valid), .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_pc(ex_pc), .ex_target(ex_target),
        .actual_outcome(actual_outcome), .branch_EX_done(branch_EX_done), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .orphan_err(orphan_err),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pred(input logic v, input logic t, input logic [31:0] pc);
        pred_valid = v;
        pred_taken = t;
        pred_pc    = pc;
    endtask

    task automatic ex(input logic v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] tgt);
        ex_valid  = v;
        ex_funct3 = f;
        ex_rs1    = a;
        ex_rs2    = b;
        ex_pc     = pc;
        ex_target = tgt;
    endtask

    initial begin
        rst_n = 1'b0;
        pred(0, 0, 0);
        ex(0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_done", branch_EX_done, 0);
        chk("rst_flush", flush, 0);
        chk("rst_bcnt", branch_cnt, 0);
        chk("rst_orphan", orphan_err, 0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", pred_ready, 1);
        // correct taken prediction
        pred(1, 1, 32'h40); step(); pred(0, 0, 0);
        ex(1, 3'b000, 5, 5, 32'h40, 32'h80); step(); ex(0, 0, 0, 0, 0, 0);
        chk("t1_done", branch_EX_done, 1);
        chk("t1_out", actual_outcome, 1);
        chk("t1_flush", flush, 0);
        chk("t1_redir", redirect_valid, 0);
        chk("t1_bcnt", branch_cnt, 1);
        step();
        chk("t1_done_pulse", branch_EX_done, 0);
        chk("t1_out_hold", actual_outcome, 1);
        // BNE mispredict -> redirect to target
        pred(1, 0, 32'h40); step(); pred(0, 0, 0);
        ex(1, 3'b001, 1, 2, 32'h40, 32'h100); step(); ex(0, 0, 0, 0, 0, 0);
        chk("t2_redir_v", redirect_valid, 1);
        chk("t2_redir_pc", redirect_pc, 32'h100);
        chk("t2_flush1", flush, 1);
        chk("t2_ready1", pred_ready, 0);
        chk("t2_mcnt", mispredict_cnt, 1);
        chk("t2_bcnt", branch_cnt, 2);
        step();
        chk("t2_flush2", flush, 1);
        chk("t2_ready2", pred_ready, 0);
        chk("t2_redir_pulse", redirect_valid, 0);
        chk("t2_redir_hold", redirect_pc, 32'h100);
        step();
        chk("t2_flush_end", flush, 0);
        chk("t2_ready_end", pred_ready, 1);
        // BLTU not taken, fall-through PC wraps
        pred(1, 1, 32'hFFFFFFFC); step(); pred(0, 0, 0);
        ex(1, 3'b110, 32'hFFFFFFFF, 1, 32'hFFFFFFFC, 32'h200); step(); ex(0, 0, 0, 0, 0, 0);
        chk("t3_out", actual_outcome, 0);
        chk("t3_redir_v", redirect_valid, 1);
        chk("t3_redir_wrap", redirect_pc, 32'h0);
        chk("t3_mcnt", mispredict_cnt, 2);
        step(); step();
        chk("t3_flush_end", flush, 0);
        // BLT signed: -1 < 1 taken
        pred(1, 1, 32'hFFFFFFFC); step(); pred(0, 0, 0);
        ex(1, 3'b100, 32'hFFFFFFFF, 1, 32'hFFFFFFFC, 32'h200); step(); ex(0, 0, 0, 0, 0, 0);
        chk("t3_blt_out", actual_outcome, 1);
        chk("t3_blt_flush", flush, 0);
        chk("t3_blt_bcnt", branch_cnt, 4);
        // fill queue, drop overflow push, then FIFO-order pops
        pred(1, 1, 32'h100); step();
        pred(1, 0, 32'h104); step();
        pred(1, 1, 32'h108); step();
        pred(1, 0, 32'h10C); step();
        chk("t4_full_ready", pred_ready, 0);
        pred(1, 1, 32'h110); step(); pred(0, 0, 0);
        chk("t4_drop_ready", pred_ready, 0);
        ex(1, 3'b000, 1, 1, 32'h100, 32'h0); step();
        chk("t4_pop1_done", branch_EX_done, 1);
        chk("t4_pop1_ready", pred_ready, 1);
        pred(1, 1, 32'h114);
        ex(1, 3'b001, 3, 3, 32'h104, 32'h0); step();
        chk("t4_pushpop_ready", pred_ready, 1);
        chk("t4_pushpop_flush", flush, 0);
        pred(1, 1, 32'h118); ex(0, 0, 0, 0, 0, 0); step(); pred(0, 0, 0);
        chk("t4_refull_ready", pred_ready, 0);
        ex(1, 3'b000, 1, 1, 32'h108, 32'h0); step();
        chk("t4_pop_108", {31'd0, branch_EX_done} | {30'd0, flush, 1'b0}, 1);
        ex(1, 3'b001, 3, 3, 32'h10C, 32'h0); step();
        chk("t4_pop_10c", {31'd0, branch_EX_done} | {30'd0, flush, 1'b0}, 1);
        ex(1, 3'b000, 1, 1, 32'h114, 32'h0); step();
        chk("t4_pop_114", {31'd0, branch_EX_done} | {30'd0, flush, 1'b0}, 1);
        ex(1, 3'b000, 1, 1, 32'h118, 32'h0); step(); ex(0, 0, 0, 0, 0, 0);
        chk("t4_pop_118", {31'd0, branch_EX_done} | {30'd0, flush, 1'b0}, 1);
        chk("t4_orphan", orphan_err, 0);
        chk("t4_bcnt", branch_cnt, 10);
        chk("t4_mcnt", mispredict_cnt, 2);
        chk("t4_empty_ready", pred_ready, 1);
        // orphan on empty queue: predicted not-taken vs actual taken
        ex(1, 3'b000, 7, 7, 32'h300, 32'h400); step(); ex(0, 0, 0, 0, 0, 0);
        chk("t5_orphan", orphan_err, 1);
        chk("t5_flush", flush, 1);
        chk("t5_redir_pc", redirect_pc, 32'h400);
        chk("t5_mcnt", mispredict_cnt, 3);
        step(); step();
        chk("t5_orphan_sticky", orphan_err, 1);
        // mispredict then async reset during first flush cycle
        pred(1, 1, 32'h500); step(); pred(0, 0, 0);
        ex(1, 3'b001, 2, 2, 32'h500, 32'h600); step(); ex(0, 0, 0, 0, 0, 0);
        chk("t6_flush", flush, 1);
        chk("t6_redir_pc", redirect_pc, 32'h504);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_flush", flush, 0);
        chk("t6_rst_bcnt", branch_cnt, 0);
        chk("t6_rst_mcnt", mispredict_cnt, 0);
        chk("t6_rst_orphan", orphan_err, 0);
        chk("t6_rst_redir_pc", redirect_pc, 0);
        #2 rst_n = 1'b1;
        // ex_valid ignored during flush; push in mispredict cycle discarded
        pred(1, 0, 32'h700); step();
        pred(1, 0, 32'h900);
        ex(1, 3'b000, 1, 1, 32'h700, 32'h800); step(); pred(0, 0, 0);
        chk("t7_flush", flush, 1);
        chk("t7_done", branch_EX_done, 1);
        chk("t7_redir_pc", redirect_pc, 32'h800);
        ex(1, 3'b000, 1, 1, 32'h700, 32'h800); step(); ex(0, 0, 0, 0, 0, 0);
        chk("t7_wrongpath_done", branch_EX_done, 0);
        chk("t7_wrongpath_bcnt", branch_cnt, 1);
        chk("t7_wrongpath_orphan", orphan_err, 0);
        step();
        chk("t7_flush_end", flush, 0);
        ex(1, 3'b000, 1, 1, 32'h900, 32'hA00); step(); ex(0, 0, 0, 0, 0, 0);
        chk("t7_discarded_push", orphan_err, 1);
        chk("t7_bcnt", branch_cnt, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
